// File: rtl/axilite_slave_if.sv
// AXI-Lite AW/W/AR/R channel bundle as seen by the responder (no B channel, no RRESP).
interface axilite_slave_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/axilite_slave.sv
// AXI-Lite responder: one write and one read in flight, funnelled onto a shared
// request/ack backend port with round-robin tie breaking and an ack timeout.
module axilite_slave #(
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    axilite_slave_if.slave        axi,
    output logic                  bk_req,
    output logic                  bk_we,
    output logic [31:0]           bk_addr,
    output logic [31:0]           bk_wdata,
    output logic [3:0]            bk_wstrb,
    input  logic                  bk_ack,
    input  logic [31:0]           bk_rdata,
    output logic                  bk_timeout
);

    localparam bit              TimeoutEn = (TIMEOUT_CYC != 0);
    localparam int unsigned     CntW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0] CntMax    = CntW'(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StWAddr, StWData, StWPend} w_state_e;
    typedef enum logic [1:0] {StRAddr, StRPend, StRData} r_state_e;
    typedef enum logic [1:0] {StBIdle, StBWr, StBRd} b_state_e;

    w_state_e        w_state_q;
    logic            awready_q, wready_q;
    logic [31:0]     waddr_q, wdata_q;
    logic [3:0]      wstrb_q;

    r_state_e        r_state_q;
    logic            arready_q, rvalid_q;
    logic [31:0]     rdata_q, raddr_q;

    b_state_e        b_state_q;
    logic            bk_req_q, bk_we_q, bk_timeout_q, last_wr_q;
    logic [31:0]     bk_addr_q, bk_wdata_q;
    logic [3:0]      bk_wstrb_q;
    logic [CntW-1:0] cnt_q;

    logic            w_pend, r_pend, grant_wr, grant_rd;
    logic            expire, bk_end, wr_done, rd_done;
    logic [31:0]     wdata_nxt, raddr_nxt;
    logic [3:0]      wstrb_nxt;

    // A transaction counts as pending on the very edge it enters its PEND state,
    // so the backend grant lands on that same edge.
    always_comb begin
        w_pend    = (w_state_q == StWPend) || ((w_state_q == StWData) && axi.wvalid);
        r_pend    = (r_state_q == StRPend) ||
                    ((r_state_q == StRAddr) && axi.arvalid && arready_q);
        grant_wr  = (b_state_q == StBIdle) && w_pend && (!r_pend || !last_wr_q);
        grant_rd  = (b_state_q == StBIdle) && r_pend && !grant_wr;
        expire    = TimeoutEn && bk_req_q && !bk_ack && (cnt_q == CntLast);
        bk_end    = bk_req_q && (bk_ack || expire);
        wr_done   = bk_end && (b_state_q == StBWr);
        rd_done   = bk_end && (b_state_q == StBRd);
        wdata_nxt = (w_state_q == StWData) ? axi.wdata : wdata_q;
        wstrb_nxt = (w_state_q == StWData) ? axi.wstrb : wstrb_q;
        raddr_nxt = (r_state_q == StRAddr) ? axi.araddr : raddr_q;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q <= StWAddr;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                StWAddr: begin
                    if (axi.awvalid && awready_q) begin
                        waddr_q   <= axi.awaddr;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= StWData;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                StWData: begin
                    if (axi.wvalid) begin
                        wdata_q   <= axi.wdata;
                        wstrb_q   <= axi.wstrb;
                        wready_q  <= 1'b0;
                        w_state_q <= StWPend;
                    end
                end
                StWPend: begin
                    if (wr_done) begin
                        awready_q <= 1'b1;
                        w_state_q <= StWAddr;
                    end
                end
                default: w_state_q <= StWAddr;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_q <= StRAddr;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            case (r_state_q)
                StRAddr: begin
                    if (axi.arvalid && arready_q) begin
                        raddr_q   <= axi.araddr;
                        arready_q <= 1'b0;
                        r_state_q <= StRPend;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                StRPend: begin
                    if (rd_done) begin
                        rvalid_q  <= 1'b1;
                        rdata_q   <= bk_ack ? bk_rdata : TIMEOUT_RDATA;
                        r_state_q <= StRData;
                    end
                end
                StRData: begin
                    if (axi.rready) begin
                        rvalid_q  <= 1'b0;
                        rdata_q   <= '0;
                        arready_q <= 1'b1;
                        r_state_q <= StRAddr;
                    end
                end
                default: r_state_q <= StRAddr;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            b_state_q    <= StBIdle;
            bk_req_q     <= 1'b0;
            bk_we_q      <= 1'b0;
            bk_addr_q    <= '0;
            bk_wdata_q   <= '0;
            bk_wstrb_q   <= '0;
            bk_timeout_q <= 1'b0;
            cnt_q        <= '0;
            last_wr_q    <= 1'b0;
        end else begin
            bk_timeout_q <= 1'b0;
            case (b_state_q)
                StBIdle: begin
                    cnt_q <= '0;
                    // Round-robin state only moves on a genuine tie.
                    if (w_pend && r_pend) begin
                        last_wr_q <= grant_wr;
                    end
                    if (grant_wr) begin
                        b_state_q  <= StBWr;
                        bk_req_q   <= 1'b1;
                        bk_we_q    <= 1'b1;
                        bk_addr_q  <= waddr_q;
                        bk_wdata_q <= wdata_nxt;
                        bk_wstrb_q <= wstrb_nxt;
                    end else if (grant_rd) begin
                        b_state_q  <= StBRd;
                        bk_req_q   <= 1'b1;
                        bk_we_q    <= 1'b0;
                        bk_addr_q  <= raddr_nxt;
                        bk_wdata_q <= '0;
                        bk_wstrb_q <= '0;
                    end
                end
                StBWr, StBRd: begin
                    if (bk_end) begin
                        b_state_q    <= StBIdle;
                        bk_req_q     <= 1'b0;
                        bk_we_q      <= 1'b0;
                        bk_addr_q    <= '0;
                        bk_wdata_q   <= '0;
                        bk_wstrb_q   <= '0;
                        bk_timeout_q <= expire;
                        cnt_q        <= '0;
                    end else if (TimeoutEn && (cnt_q != CntMax)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: b_state_q <= StBIdle;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign bk_req      = bk_req_q;
    assign bk_we       = bk_we_q;
    assign bk_addr     = bk_addr_q;
    assign bk_wdata    = bk_wdata_q;
    assign bk_wstrb    = bk_wstrb_q;
    assign bk_timeout  = bk_timeout_q;

endmodule

// File: tb/tb_axilite_slave.sv
// Directed bench for axilite_slave: vector table of single transactions plus
// hand sequences for early W, write/read ties and reset during a backend read.
module tb_axilite_slave;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axilite_slave_if axi();

    logic        bk_req, bk_we, bk_ack, bk_timeout;
    logic [31:0] bk_addr, bk_wdata, bk_rdata;
    logic [3:0]  bk_wstrb;

    axilite_slave #(
        .TIMEOUT_CYC   (TO),
        .TIMEOUT_RDATA (32'hFFFF_FFFF)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .axi         (axi),
        .bk_req      (bk_req),
        .bk_we       (bk_we),
        .bk_addr     (bk_addr),
        .bk_wdata    (bk_wdata),
        .bk_wstrb    (bk_wstrb),
        .bk_ack      (bk_ack),
        .bk_rdata    (bk_rdata),
        .bk_timeout  (bk_timeout)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          delay;
        int          hold;
        logic [31:0] exp_rdata;
        int          exp_to;
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0;
    int n_fail = 0;
    string cur_tag = "";

    // Backend model state
    int          ack_delay = 0;
    logic [31:0] resp_data = '0;
    int          age = 0;
    bit          req_prev = 0, ack_prev = 0;
    int          req_starts = 0, to_pulses = 0, gap_err = 0, hold_err = 0;
    bit          snap_we;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_wstrb;
    bit          grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: actual=%h required=%h", cur_tag, name, act, exp);
        end
    endtask

    task automatic clr_model();
        req_starts = 0;
        to_pulses  = 0;
        gap_err    = 0;
        hold_err   = 0;
        grant_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bk_timeout) to_pulses++;
        if (bk_req) begin
            if (!req_prev) begin
                req_starts++;
                age        = 0;
                snap_we    = bk_we;
                snap_addr  = bk_addr;
                snap_wdata = bk_wdata;
                snap_wstrb = bk_wstrb;
                grant_log.push_back(bk_we);
            end else begin
                age++;
                if (ack_prev || age >= int'(TO)) gap_err++;
                if ({bk_we, bk_addr, bk_wdata, bk_wstrb} !==
                    {snap_we, snap_addr, snap_wdata, snap_wstrb}) hold_err++;
            end
            bk_ack = (ack_delay >= 0) && (age == ack_delay);
        end else begin
            bk_ack = 1'b0;
        end
        bk_rdata = bk_ack ? resp_data : 32'h0;
        ack_prev = bk_ack;
        req_prev = bk_req;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int exp_lat;
        bit stable;
        cur_tag   = tag;
        clr_model();
        ack_delay = v.delay;
        resp_data = v.data;
        exp_lat   = (v.delay < 0 || v.delay >= int'(TO)) ? int'(TO) : v.delay + 1;
        if (v.wr) begin
            axi.awvalid = 1'b1;
            axi.awaddr  = v.addr;
            tick();
            axi.awvalid = 1'b0;
            chk("wready_after_aw", axi.wready, 1);
            axi.wvalid = 1'b1;
            axi.wdata  = v.data;
            axi.wstrb  = v.strb;
            tick();
            axi.wvalid = 1'b0;
            chk("bk_req_after_w", bk_req, 1);
            n = 0;
            while (!axi.awready && n < 40) begin
                tick();
                n++;
            end
            chk("wr_latency", n, exp_lat);
            tick();
            chk("bk_we", snap_we, 1);
            chk("bk_addr", snap_addr, v.addr);
            chk("bk_wdata", snap_wdata, v.data);
            chk("bk_wstrb", snap_wstrb, v.strb);
        end else begin
            axi.arvalid = 1'b1;
            axi.araddr  = v.addr;
            tick();
            axi.arvalid = 1'b0;
            chk("bk_req_after_ar", bk_req, 1);
            n = 0;
            while (!axi.rvalid && n < 40) begin
                tick();
                n++;
            end
            chk("rd_latency", n, exp_lat);
            chk("rdata", axi.rdata, v.exp_rdata);
            if (v.hold > 0) begin
                stable = 1;
                for (int i = 0; i < v.hold; i++) begin
                    tick();
                    if (!axi.rvalid || axi.rdata !== v.exp_rdata) stable = 0;
                end
                chk("rdata_hold", stable, 1);
            end
            axi.rready = 1'b1;
            tick();
            axi.rready = 1'b0;
            chk("rvalid_after_rready", axi.rvalid, 0);
            chk("rdata_zero_idle", axi.rdata, 0);
            chk("arready_after_rready", axi.arready, 1);
            chk("bk_we", snap_we, 0);
            chk("bk_addr", snap_addr, v.addr);
            chk("bk_wstrb", snap_wstrb, 0);
        end
        chk("req_count", req_starts, 1);
        chk("timeout_pulses", to_pulses, v.exp_to);
        chk("gap_err", gap_err, 0);
        chk("hold_err", hold_err, 0);
    endtask

    task automatic tie_round(input bit exp_first_wr, input string tag);
        int n;
        cur_tag   = tag;
        clr_model();
        ack_delay = 0;
        resp_data = 32'h5555_AAAA;
        axi.awvalid = 1'b1;
        axi.awaddr  = 32'h0000_0100;
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b1;
        axi.wdata   = 32'h0F0F_0F0F;
        axi.wstrb   = 4'hF;
        axi.arvalid = 1'b1;
        axi.araddr  = 32'h0000_0200;
        tick();
        axi.wvalid  = 1'b0;
        axi.arvalid = 1'b0;
        n = 0;
        while (!(axi.awready && axi.rvalid) && n < 40) begin
            tick();
            n++;
        end
        chk("both_done", {axi.awready, axi.rvalid}, 2'b11);
        chk("tie_rdata", axi.rdata, 32'h5555_AAAA);
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        chk("grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("first_grant_we", grant_log[0], exp_first_wr);
            chk("second_grant_we", grant_log[1], !exp_first_wr);
        end
        chk("gap_err", gap_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   ok;

        vecs[0] = '{1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 0, 0, 32'h0, 0};
        vecs[1] = '{1'b0, 32'h3000_0020, 32'hCAFE_F00D, 4'h0, 3, 5, 32'hCAFE_F00D, 0};
        vecs[2] = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'h5, 2, 0, 32'h0, 0};
        vecs[3] = '{1'b0, 32'h0000_0100, 32'h1357_9BDF, 4'h0, -1, 2, 32'hFFFF_FFFF, 1};
        vecs[4] = '{1'b0, 32'h0000_0104, 32'h1234_5678, 4'h0, 7, 1, 32'h1234_5678, 0};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h8, -1, 0, 32'h0, 1};
        vecs[6] = '{1'b0, 32'h0000_000C, 32'h0BAD_F00D, 4'h0, 0, 0, 32'h0BAD_F00D, 0};

        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.rready  = 1'b0;
        bk_ack      = 1'b0;
        bk_rdata    = '0;

        cur_tag = "reset";
        #3;
        chk("outs_in_reset", {axi.awready, axi.wready, axi.arready, axi.rvalid, bk_req,
                              bk_timeout}, 6'b0);
        chk("rdata_in_reset", axi.rdata, 0);
        #20;
        rst_n = 1'b1;
        #1;
        chk("awready_before_edge", axi.awready, 0);
        tick();
        chk("awready_first_edge", axi.awready, 1);
        chk("arready_first_edge", axi.arready, 1);
        chk("wready_idle", axi.wready, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // W presented before AW must wait for the AW handshake.
        cur_tag = "early_w";
        clr_model();
        ack_delay   = 0;
        axi.wvalid  = 1'b1;
        axi.wdata   = 32'h1111_DEAD;
        axi.wstrb   = 4'h3;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (axi.wready !== 1'b0 || bk_req !== 1'b0) ok = 0;
        end
        chk("wready_low_before_aw", ok, 1);
        axi.awvalid = 1'b1;
        axi.awaddr  = 32'h0000_0040;
        tick();
        axi.awvalid = 1'b0;
        chk("wready_after_aw", axi.wready, 1);
        chk("no_req_yet", bk_req, 0);
        axi.wdata = 32'h2222_BEEF;
        axi.wstrb = 4'hC;
        tick();
        axi.wvalid = 1'b0;
        chk("bk_req", bk_req, 1);
        chk("bk_wdata", bk_wdata, 32'h2222_BEEF);
        chk("bk_wstrb", bk_wstrb, 4'hC);
        ok = 0;
        while (!axi.awready && ok < 40) begin
            tick();
            ok++;
        end
        chk("awready_back", axi.awready, 1);
        chk("req_count", req_starts, 1);

        tie_round(1'b1, "tie1");
        tie_round(1'b0, "tie2");

        // Reset in the middle of a backend read.
        cur_tag = "reset_brd";
        clr_model();
        ack_delay   = -1;
        axi.arvalid = 1'b1;
        axi.araddr  = 32'h0000_0300;
        tick();
        axi.arvalid = 1'b0;
        tick();
        tick();
        chk("bk_req_before_rst", bk_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("outs_async_rst", {bk_req, axi.rvalid, axi.awready, axi.arready}, 4'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        req_prev = 0;
        ack_prev = 0;
        bk_ack   = 1'b0;
        #1;
        chk("arready_before_edge", axi.arready, 0);
        clr_model();
        tick();
        chk("arready_after_rel", axi.arready, 1);
        tick();
        tick();
        chk("no_stale_req", req_starts, 0);
        v = '{1'b0, 32'h0000_0020, 32'h7777_0001, 4'h0, 1, 0, 32'h7777_0001, 0};
        run_vec(v, "post_reset_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axilite_slave.md
Name: axilite_slave

Overview:
- AXI-Lite responder, the far end of the team's AXI-Lite master subset: AW, W, AR and R channels only, with no B channel and no RRESP.
- Accepts one write and one read transaction at a time.
- Forwards each transaction over a single shared request/ack backend port to a register file or bridge; write and read contend through round-robin arbitration.
- Includes a backend-ack timeout so a dead backend cannot hang the bus.

Parameters:
TIMEOUT_CYC, 255, backend cycles to wait for bk_ack before forced completion; 0 disables the timeout.
TIMEOUT_RDATA, 32'hFFFF_FFFF, read data returned on a timed-out read.

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset, asynchronous, active-low
axi_awvalid  in  1  write address valid
axi_awaddr  in  32  write address
axi_awready  out  1  write address ready
axi_wvalid  in  1  write data valid
axi_wdata  in  32  write data
axi_wstrb  in  4  write byte strobes
axi_wready  out  1  write data ready
axi_arvalid  in  1  read address valid
axi_araddr  in  32  read address
axi_arready  out  1  read address ready
axi_rvalid  out  1  read data valid
axi_rdata  out  32  read data
axi_rready  in  1  read data ready
bk_req  out  1  backend request, held until ack or timeout
bk_we  out  1  1 = write, 0 = read; valid while bk_req
bk_addr  out  32  backend address
bk_wdata  out  32  backend write data
bk_wstrb  out  4  backend strobes; 0 on reads
bk_ack  in  1  backend completion, sampled only while bk_req=1
bk_rdata  in  32  read data, valid with bk_ack on reads
bk_timeout  out  1  one-cycle pulse when a request times out

Behaviour:
- Reset (axi_aresetn low): all outputs 0 immediately; pending transactions discarded; last-grant flag = read.
- axi_awready and axi_arready first go 1 on the first rising edge after reset release.
- Write FSM:
  - W_ADDR (awready=1): on awvalid&&awready, capture awaddr -> W_DATA.
  - W_DATA (wready=1): on wvalid, capture wdata/wstrb -> W_PEND.
  - W_PEND: no readies; waits for grant and completion -> W_ADDR.
  - W data is never accepted before AW; wvalid in W_ADDR is ignored.
- Read FSM:
  - R_ADDR (arready=1): on arvalid, capture araddr -> R_PEND.
  - R_PEND: waits for completion, captures data -> R_DATA.
  - R_DATA: rvalid=1 and rdata = captured data, stable until rready; on rready -> R_ADDR.
  - rdata = 0 whenever rvalid=0.
- Backend FSM (B_IDLE, B_WR, B_RD), registered outputs:
  - B_IDLE with exactly one of W_PEND/R_PEND: grant it. bk_req=1, with bk_we/addr/wdata/wstrb set from the edge after entering the PEND state.
  - Both pending in the same cycle: grant the opposite of the last grant. After reset the first tie goes to write.
  - B_WR/B_RD: bk_req and the payload are held constant.
  - bk_ack=1 at an edge ends the request. bk_req=0 from that edge.
  - Completion of the owning FSM takes effect at that edge: W_PEND -> W_ADDR (awready=1 next cycle); R_PEND -> R_DATA (rvalid=1 next cycle, rdata = bk_rdata sampled at the ack edge).
- Back-to-back: B_IDLE lasts at least one cycle between requests. A new grant cannot assert bk_req on the cycle right after an ack.
- Timeout: counter cleared on grant, incremented each cycle bk_req=1 without bk_ack.
  - When the count reaches TIMEOUT_CYC: bk_req drops, bk_timeout pulses for 1 cycle, and the transaction completes as if acked.
  - A timed-out read returns TIMEOUT_RDATA.
  - bk_ack on the same edge as expiry: the ack wins, with no bk_timeout pulse.
  - Counter width is clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- Write latency, backend idle and 0-cycle ack backend:
  - AW edge E; wready=1 in E+1.
  - W edge E+1; bk_req=1 in E+2.
  - Ack edge E+2; awready=1 in E+3.
- Read latency under the same conditions:
  - AR edge E; bk_req in E+1.
  - Ack edge E+1; rvalid in E+2.
- axi_rready low holds R_DATA indefinitely with no timeout. The next AR is not accepted until rready.
- A write may run on the backend while a read sits in R_DATA.

Test Plan:
- Single write to awaddr=0x3000_0010, wdata=0xA5A5_1234, wstrb=0xF; bk_ack the cycle after bk_req -> one bk_req pulse with bk_we=1 and exact payload; awready back to 1 three cycles after the AW handshake.
- Read from 0x3000_0020; backend returns 0xCAFE_F00D after 3 wait cycles -> rvalid with rdata=0xCAFE_F00D; rready held low 5 cycles keeps rvalid=1 and rdata stable.
- AW/W and AR issued so W_PEND and R_PEND arise on the same cycle, repeated twice -> first grant write, second tie grant read; bk_req never asserted on consecutive cycles across requests.
- TIMEOUT_CYC=8, no ack on a read -> bk_req drops after 8 cycles, one bk_timeout pulse, rdata=0xFFFF_FFFF; then ack on the 8th cycle in a rerun -> normal data, no bk_timeout.
- axi_aresetn asserted low while bk_req=1 in B_RD -> bk_req, rvalid, awready and arready 0 immediately; after release the first AR completes normally and no stale request is issued.
- wvalid asserted before awvalid -> wready stays 0 until the AW handshake; data captured only afterwards.
